dwa_element_selector: RTL and testbench
=======================================

Name: dwa_element_selector

Overview:
- Downstream stage of the second-order IIR notch noise-shaping filter in the DEM-DAC datapath.
- Consumes the filter's signed WIDTH-bit NTF output and quantizes it to NUM_ELEM+1 levels with rounding.
- Drives the unit-element enable vector using data-weighted averaging (DWA): a rotating pointer spreads element usage so that element mismatch is first-order noise-shaped.
- Output feeds the unit-element switch block of the DAC.

Parameters:
- WIDTH, 16, width of the signed input sample; matches the notch filter NTF output width.
- NUM_ELEM, 16, number of unit DAC elements; must be a power of 2 with 2 <= NUM_ELEM <= 2^(WIDTH-1).

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- x_in_i  input  WIDTH  signed two's-complement sample (NTF output of the notch filter).
- valid_i  input  1  x_in_i is valid this cycle.
- dwa_en_i  input  1  1 = DWA rotation; 0 = fixed thermometer from element 0.
- code_o  output  $clog2(NUM_ELEM+1)  quantized level, 0..NUM_ELEM.
- elem_en_o  output  NUM_ELEM  unit-element enables; bit i drives element i.
- ptr_o  output  $clog2(NUM_ELEM)  current DWA pointer (next start element).
- valid_o  output  1  elem_en_o was updated this cycle.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset: code_o=0, elem_en_o=0, ptr_o=0, valid_o=0, all internal pipeline state=0. Reset has priority over every other input.
- Quantizer (stage 1, latency 1):
  - Let SHIFT = WIDTH - log2(NUM_ELEM).
  - u = x_in_i + 2^(WIDTH-1) + 2^(SHIFT-1), computed unsigned on WIDTH+2 bits with no overflow.
  - code = u >> SHIFT. The range is exactly 0..NUM_ELEM, so no saturation is needed.
  - Registered when valid_i=1; stage-1 valid bit = valid_i.
- Selector (stage 2, latency 1 more; 2 cycles total from x_in_i to elem_en_o):
  - Active only when stage-1 valid=1. It sets valid_o=1 and code_o to the stage-1 code.
  - DWA (dwa_en_i=1): enable elements ptr, ptr+1, ..., ptr+code-1, all mod NUM_ELEM. Next ptr = (ptr+code) mod NUM_ELEM.
  - Thermometer (dwa_en_i=0): enable elements 0..code-1. ptr is held.
  - dwa_en_i is sampled in the same cycle that stage 2 updates.
- Boundary cases:
  - code=0: elem_en_o=0, ptr unchanged.
  - code=NUM_ELEM: elem_en_o all ones, ptr unchanged (full wrap).
  - Wrap-around: the enabled set may span element NUM_ELEM-1 to element 0, contiguous mod NUM_ELEM.
- Gaps: when stage-1 valid=0, valid_o=0 next cycle. elem_en_o, code_o and ptr_o hold their last values, so the DAC keeps its last level.
- Back-to-back valid samples: one update per cycle, no bubbles, no backpressure.
- Reset mid-stream: in-flight samples are discarded and the pointer returns to 0. The first valid after reset release produces valid_o two cycles later.
- Invariant: popcount(elem_en_o) == code_o whenever valid_o=1.

Test Plan (WIDTH=16, NUM_ELEM=16):
- Reset held for 2 cycles, then released with valid_i=0 -> code_o=0, elem_en_o=0x0000, ptr_o=0, valid_o=0.
- Two valid samples, x=0 then x=0 -> code 8 each.
  - First valid_o (2 cycles after the first sample): elem_en_o=0x00FF, then ptr_o=8.
  - Next: elem_en_o=0xFF00, then ptr_o=0.
- Wrap check: x=0, then x=-12288 twice (code 5 each).
  - First: 0x00FF, ptr 8.
  - Second: 0x1F00, ptr 13.
  - Third: 0xE003, ptr 2.
- Extremes:
  - x=0x7FFF -> code 16, elem_en_o=0xFFFF, ptr unchanged.
  - x=-32768 -> code 0, elem_en_o=0x0000, ptr unchanged.
- dwa_en_i=0, three samples x=0 -> elem_en_o=0x00FF every time, ptr_o stays at its prior value. Re-enabling DWA resumes from the held ptr.
- Valid gaps and reset:
  - x=0 valid, then valid_i=0 for 3 cycles -> valid_o=0 during the gap, elem_en_o held at 0x00FF, ptr held at 8.
  - Assert reset_i for one cycle while a valid sample is in flight -> next cycle all outputs 0 and the in-flight sample never appears.
- Reference-model scoreboard:
  - 1000 random x values with random valid_i and dwa_en_i, compared against a behavioural model.
  - popcount(elem_en_o)==code_o on every valid_o.
  - Per-element usage counts differ by at most 1 whenever ptr_o returns to 0 with dwa_en_i=1 throughout.

Source files
------------

// File: rtl/dwa_element_selector_if.sv
// Sample-in / element-enables-out bundle between the notch filter, the DWA
// selector and the DAC unit-element switch block.
interface dwa_element_selector_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_ELEM = 16
);
  localparam int CW = $clog2(NUM_ELEM + 1);
  localparam int PW = $clog2(NUM_ELEM);

  logic signed [WIDTH-1:0] x_in_i;
  logic                    valid_i;
  logic                    dwa_en_i;
  logic [CW-1:0]           code_o;
  logic [NUM_ELEM-1:0]     elem_en_o;
  logic [PW-1:0]           ptr_o;
  logic                    valid_o;

  modport master (
    output x_in_i, valid_i, dwa_en_i,
    input  code_o, elem_en_o, ptr_o, valid_o
  );

  modport slave (
    input  x_in_i, valid_i, dwa_en_i,
    output code_o, elem_en_o, ptr_o, valid_o
  );
endinterface

// File: rtl/dwa_element_selector.sv
// Rounding quantizer to NUM_ELEM+1 levels followed by a data-weighted-averaging
// unit-element selector; two-cycle latency from sample to element enables.
module dwa_element_selector #(
  parameter int WIDTH    = 16,
  parameter int NUM_ELEM = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  dwa_element_selector_if.slave  bus
);
  localparam int CW    = $clog2(NUM_ELEM + 1);
  localparam int PW    = $clog2(NUM_ELEM);
  localparam int SHIFT = WIDTH - PW;

  // Offset-binary plus half an LSB of the output grid, then truncate.
  // WIDTH+1 bits already hold the largest sum, so nothing overflows.
  function automatic logic [CW-1:0] quantize(input logic signed [WIDTH-1:0] x);
    logic [WIDTH:0] u;
    u = {1'b0, ~x[WIDTH-1], x[WIDTH-2:0]} + ((WIDTH+1)'(1) << (SHIFT - 1));
    return u[WIDTH:SHIFT];
  endfunction

  function automatic logic [NUM_ELEM-1:0] thermometer(input logic [CW-1:0] c);
    logic [NUM_ELEM-1:0] m;
    for (int i = 0; i < NUM_ELEM; i++) begin
      m[i] = (CW'(i) < c);
    end
    return m;
  endfunction

  // Cyclic rotate-left; PW-bit index arithmetic supplies the mod NUM_ELEM wrap.
  function automatic logic [NUM_ELEM-1:0] rotate_left(input logic [NUM_ELEM-1:0] m,
                                                      input logic [PW-1:0]       p);
    logic [NUM_ELEM-1:0] r;
    for (int i = 0; i < NUM_ELEM; i++) begin
      r[i] = m[PW'(PW'(i) - p)];
    end
    return r;
  endfunction

  logic                vld_p1_q, vld_p1_d;
  logic [CW-1:0]       code_p1_q, code_p1_d;
  logic                vld_p2_q, vld_p2_d;
  logic [CW-1:0]       code_p2_q, code_p2_d;
  logic [NUM_ELEM-1:0] elem_en_p2_q, elem_en_p2_d;
  logic [PW-1:0]       ptr_p2_q, ptr_p2_d;
  logic [CW-1:0]       ptr_sum;

  always_comb begin
    // Stage 1: quantize
    vld_p1_d  = bus.valid_i;
    code_p1_d = code_p1_q;
    if (bus.valid_i) begin
      code_p1_d = quantize(bus.x_in_i);
    end

    // Stage 2: select elements; outputs hold across gaps so the DAC keeps its level
    vld_p2_d     = vld_p1_q;
    code_p2_d    = code_p2_q;
    elem_en_p2_d = elem_en_p2_q;
    ptr_p2_d     = ptr_p2_q;
    ptr_sum      = CW'(ptr_p2_q) + code_p1_q;
    if (vld_p1_q) begin
      code_p2_d = code_p1_q;
      if (bus.dwa_en_i) begin
        elem_en_p2_d = rotate_left(thermometer(code_p1_q), ptr_p2_q);
        ptr_p2_d     = ptr_sum[PW-1:0];
      end else begin
        elem_en_p2_d = thermometer(code_p1_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1_q     <= 1'b0;
      code_p1_q    <= '0;
      vld_p2_q     <= 1'b0;
      code_p2_q    <= '0;
      elem_en_p2_q <= '0;
      ptr_p2_q     <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      code_p1_q    <= code_p1_d;
      vld_p2_q     <= vld_p2_d;
      code_p2_q    <= code_p2_d;
      elem_en_p2_q <= elem_en_p2_d;
      ptr_p2_q     <= ptr_p2_d;
    end
  end

  assign bus.code_o    = code_p2_q;
  assign bus.elem_en_o = elem_en_p2_q;
  assign bus.ptr_o     = ptr_p2_q;
  assign bus.valid_o   = vld_p2_q;
endmodule

// File: tb/tb_dwa_element_selector.sv
// Bench for dwa_element_selector: directed spec scenarios plus randomized
// traffic against a cycle-level behavioural model of the quantizer and DWA.
module tb_dwa_element_selector;
  localparam int WIDTH = 16;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dwa_element_selector_if #(.WIDTH(WIDTH), .NUM_ELEM(N)) bus ();

  dwa_element_selector #(.WIDTH(WIDTH), .NUM_ELEM(N)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Behavioural model: one-sample delay slot, then element selection.
  bit          m_s1v = 0;
  int          m_s1c = 0;
  bit          m_vo = 0;
  int          m_code = 0;
  int          m_ptr = 0;
  logic [15:0] m_en = '0;

  bit track = 0;
  int use_cnt[N];
  int n_epochs = 0;

  function automatic int qref(int x);
    return (x + 32768 + 2048) / 4096;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge(int x, bit v, bit d);
    int start;
    if (rst) begin
      m_s1v = 0; m_s1c = 0; m_vo = 0; m_code = 0; m_ptr = 0; m_en = '0;
    end else begin
      if (m_s1v) begin
        m_vo   = 1;
        m_code = m_s1c;
        m_en   = '0;
        start  = d ? m_ptr : 0;
        for (int k = 0; k < m_code; k++) m_en[(start + k) % N] = 1'b1;
        if (d) m_ptr = (m_ptr + m_code) % N;
      end else begin
        m_vo = 0;
      end
      m_s1v = v;
      if (v) m_s1c = qref(x);
    end
  endtask

  task automatic step(int x, bit v, bit d);
    int mx, mn;
    bus.x_in_i   = WIDTH'(x);
    bus.valid_i  = v;
    bus.dwa_en_i = d;
    @(posedge clk);
    model_edge(x, v, d);
    #1;
    chk("valid_o",   32'(bus.valid_o),   32'(m_vo));
    chk("code_o",    32'(bus.code_o),    32'(m_code));
    chk("elem_en_o", 32'(bus.elem_en_o), 32'(m_en));
    chk("ptr_o",     32'(bus.ptr_o),     32'(m_ptr));
    if (bus.valid_o === 1'b1) begin
      chk("popcount", 32'($countones(bus.elem_en_o)), 32'(m_code));
      if (track) begin
        for (int i = 0; i < N; i++) use_cnt[i] += int'(bus.elem_en_o[i]);
        if (bus.ptr_o == 0) begin
          mx = use_cnt[0]; mn = use_cnt[0];
          for (int i = 1; i < N; i++) begin
            if (use_cnt[i] > mx) mx = use_cnt[i];
            if (use_cnt[i] < mn) mn = use_cnt[i];
          end
          chk("usage_spread", 32'(mx - mn <= 1), 32'd1);
          n_epochs++;
        end
      end
    end
  endtask

  task automatic dchk(string tag, bit vo, logic [15:0] en, int ptr);
    chk({tag, "_valid"}, 32'(bus.valid_o),   32'(vo));
    chk({tag, "_en"},    32'(bus.elem_en_o), 32'(en));
    chk({tag, "_ptr"},   32'(bus.ptr_o),     32'(ptr));
  endtask

  initial begin
    bus.x_in_i   = '0;
    bus.valid_i  = 1'b0;
    bus.dwa_en_i = 1'b1;

    // Reset for two cycles, release with no valid input
    rst = 1'b1;
    step(0, 0, 1);
    step(0, 0, 1);
    rst = 1'b0;
    step(0, 0, 1);
    dchk("reset", 0, 16'h0000, 0);
    chk("reset_code", 32'(bus.code_o), 32'd0);

    // Two mid-scale samples
    step(0, 1, 1);
    step(0, 1, 1);
    dchk("mid1", 1, 16'h00FF, 8);
    step(0, 0, 1);
    dchk("mid2", 1, 16'hFF00, 0);

    // Wrap-around
    step(0, 1, 1);
    step(-12288, 1, 1);
    dchk("wrap1", 1, 16'h00FF, 8);
    step(-12288, 1, 1);
    dchk("wrap2", 1, 16'h1F00, 13);
    step(0, 0, 1);
    dchk("wrap3", 1, 16'hE003, 2);

    // Extremes
    step(32767, 1, 1);
    step(-32768, 1, 1);
    dchk("full", 1, 16'hFFFF, 2);
    chk("full_code", 32'(bus.code_o), 32'd16);
    step(0, 0, 1);
    dchk("zero", 1, 16'h0000, 2);
    chk("zero_code", 32'(bus.code_o), 32'd0);

    // Thermometer mode holds the pointer
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, (i < 2), 0);
      dchk("therm", 1, 16'h00FF, 2);
    end
    step(0, 1, 1);
    step(0, 0, 1);
    dchk("resume", 1, 16'h03FC, 10);

    // Reset with a sample in flight
    step(0, 1, 1);
    rst = 1'b1;
    step(0, 1, 1);
    rst = 1'b0;
    dchk("rst_mid", 0, 16'h0000, 0);
    step(0, 0, 1);
    dchk("rst_drop", 0, 16'h0000, 0);

    // Valid gap holds outputs
    step(0, 1, 1);
    step(0, 0, 1);
    dchk("gap0", 1, 16'h00FF, 8);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      dchk("gap", 0, 16'h00FF, 8);
    end

    // Random traffic, mixed modes
    for (int i = 0; i < 1000; i++) begin
      int x;
      case ($urandom_range(0, 9))
        0:       x = 32767;
        1:       x = -32768;
        default: x = int'($urandom_range(0, 65535)) - 32768;
      endcase
      step(x, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    // Random traffic, DWA only, tracking element usage from pointer 0
    rst = 1'b1;
    step(0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) use_cnt[i] = 0;
    track = 1;
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 3) != 0), 1);
    end
    track = 0;
    chk("usage_epochs", 32'(n_epochs > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
